// File: rtl/mux_scan_sampler_if.sv
// Handshake and mux-side bundle for mux_scan_sampler.
// master: sampler side (drives sel_o/busy/result); slave: host/consumer side.
interface mux_scan_sampler_if #(
  parameter int N = 9,
  parameter int m = 4
);
  logic         start;
  logic         abort;
  logic [m-1:0] sel_o;
  logic         mout_i;
  logic         busy;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_data;

  modport master (
    input  start, abort, mout_i, res_ready,
    output sel_o, busy, res_valid, res_data
  );

  modport slave (
    output start, abort, mout_i, res_ready,
    input  sel_o, busy, res_valid, res_data
  );
endinterface

// File: rtl/mux_scan_sampler.sv
// Steps an N:1 mux select 0..N-1, settles, samples each bit into a snapshot.
// Ports: clk, rst (sync, active-high), bus (start/abort/sel/mout/busy/result).
module mux_scan_sampler #(
  parameter int N      = 9,
  parameter int m      = 4,
  parameter int SETTLE = 2,
  parameter int CW     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mux_scan_sampler_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_VALID
  } state_t;

  localparam bit HAS_SETTLE = (SETTLE > 0);
  localparam logic [CW-1:0] CNT_LAST =
    HAS_SETTLE ? CW'(SETTLE - 1) : '0;
  localparam logic [m-1:0] SEL_LAST = m'(N - 1);

  state_t       state_q, state_d;
  logic [m-1:0] sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] data_q, data_d;
  logic         busy_q, valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      // registered decodes of the upcoming state
      busy_q  <= (state_d == S_SETTLE) ||
                 (state_d == S_SAMPLE);
      valid_q <= (state_d == S_VALID);
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        sel_d = '0;
        if (bus.start) begin
          cnt_d   = '0;
          state_d = HAS_SETTLE ? S_SETTLE : S_SAMPLE;
        end
      end
      S_SETTLE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          sel_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = S_SAMPLE;
          end
        end
      end
      S_SAMPLE: begin
        if (bus.abort) begin
          // abort wins over the sample, even the last one
          state_d = S_IDLE;
          sel_d   = '0;
          cnt_d   = '0;
        end else begin
          for (int i = 0; i < N; i++) begin
            if (sel_q == m'(i)) begin
              data_d[i] = bus.mout_i;
            end
          end
          if (sel_q == SEL_LAST) begin
            state_d = S_VALID;
          end else begin
            sel_d   = sel_q + 1'b1;
            cnt_d   = '0;
            state_d = HAS_SETTLE ? S_SETTLE : S_SAMPLE;
          end
        end
      end
      S_VALID: begin
        if (bus.res_ready) begin
          state_d = S_IDLE;
          sel_d   = '0;
        end
      end
    endcase
  end

  assign bus.sel_o     = sel_q;
  assign bus.busy      = busy_q;
  assign bus.res_valid = valid_q;
  assign bus.res_data  = data_q;

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Directed bench for mux_scan_sampler: three configurations, hand-computed vectors.
// Covers reset, full scans, SETTLE=0, backpressure, abort and N=1.
module tb_mux_scan_sampler;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   n;
  logic err;
  logic [8:0] snap;
  logic [8:0] pat0;
  logic [8:0] pat1;
  logic       pat2;

  mux_scan_sampler_if #(.N(9), .m(4)) if0 ();
  mux_scan_sampler_if #(.N(9), .m(4)) if1 ();
  mux_scan_sampler_if #(.N(1), .m(1)) if2 ();

  assign if0.mout_i = pat0[if0.sel_o];
  assign if1.mout_i = pat1[if1.sel_o];
  assign if2.mout_i = pat2;

  mux_scan_sampler #(.N(9), .m(4), .SETTLE(2), .CW(4)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  mux_scan_sampler #(.N(9), .m(4), .SETTLE(0), .CW(4)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  mux_scan_sampler #(.N(1), .m(1), .SETTLE(1), .CW(2)) u2 (
    .clk (clk),
    .rst (rst),
    .bus (if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    pat0  = 9'h1FF;
    pat1  = 9'h0;
    pat2  = 1'b1;
    if0.start = 0; if0.abort = 0; if0.res_ready = 0;
    if1.start = 0; if1.abort = 0; if1.res_ready = 0;
    if2.start = 0; if2.abort = 0; if2.res_ready = 0;
    tick();
    tick();
    rst = 1'b0;
    check("rst0_sel",   32'(if0.sel_o), 0);
    check("rst0_busy",  32'(if0.busy), 0);
    check("rst0_valid", 32'(if0.res_valid), 0);
    check("rst0_data",  32'(if0.res_data), 0);

    // mid-scan reset: bit0 already captured as 1 before rst
    if0.start = 1;
    tick();
    if0.start = 0;
    repeat (4) tick();
    check("mid_busy", 32'(if0.busy), 1);
    check("mid_bit0", 32'(if0.res_data[0]), 1);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst1_sel",   32'(if0.sel_o), 0);
    check("rst1_busy",  32'(if0.busy), 0);
    check("rst1_valid", 32'(if0.res_valid), 0);
    check("rst1_data",  32'(if0.res_data), 0);

    // full scan, SETTLE=2: sel j held 3 cycles, valid 28 edges after start
    pat0 = 9'h15A;
    repeat (3) tick();
    if0.start = 1;
    tick();
    if0.start = 0;
    n = 1;
    err = 0;
    while (!if0.res_valid && n < 100) begin
      if (if0.sel_o !== 4'((n - 1) / 3)) err = 1;
      if (if0.busy !== 1'b1) err = 1;
      tick();
      n++;
    end
    check("scan_seq", 32'(err), 0);
    check("scan_lat", 32'(n), 28);
    check("scan_data", 32'(if0.res_data), 32'h15A);
    check("scan_sel8", 32'(if0.sel_o), 8);
    check("scan_busy", 32'(if0.busy), 0);

    // backpressure: start and abort pulsed while VALID are ignored
    snap = if0.res_data;
    err  = 0;
    for (int i = 0; i < 5; i++) begin
      if0.start = (i == 1);
      if0.abort = (i == 3);
      tick();
      if (if0.res_valid !== 1'b1) err = 1;
      if (if0.res_data !== snap) err = 1;
      if (if0.busy !== 1'b0) err = 1;
      if (if0.sel_o !== 4'd8) err = 1;
    end
    if0.start = 0;
    if0.abort = 0;
    check("bp_stable", 32'(err), 0);
    if0.res_ready = 1;
    tick();
    if0.res_ready = 0;
    check("acc_valid", 32'(if0.res_valid), 0);
    check("acc_busy",  32'(if0.busy), 0);
    check("acc_sel",   32'(if0.sel_o), 0);
    tick();
    check("idle_busy", 32'(if0.busy), 0);

    // fresh scan after accept
    pat0 = 9'h0A5;
    if0.start = 1;
    tick();
    if0.start = 0;
    n = 1;
    while (!if0.res_valid && n < 100) begin
      tick();
      n++;
    end
    check("scan2_lat", 32'(n), 28);
    check("scan2_data", 32'(if0.res_data), 32'h0A5);
    if0.res_ready = 1;
    tick();
    if0.res_ready = 0;

    // abort while sampling sel 4: bits 3:0 new, 8:4 keep 0A5
    pat0 = 9'h1F0;
    if0.start = 1;
    tick();
    if0.start = 0;
    repeat (14) tick();
    check("ab_sel",  32'(if0.sel_o), 4);
    check("ab_busy", 32'(if0.busy), 1);
    if0.abort = 1;
    tick();
    if0.abort = 0;
    check("ab_idle_sel",  32'(if0.sel_o), 0);
    check("ab_idle_busy", 32'(if0.busy), 0);
    check("ab_data", 32'(if0.res_data), 32'h0A0);
    err = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (if0.res_valid !== 1'b0) err = 1;
    end
    check("ab_novalid", 32'(err), 0);

    // SETTLE=0: sel advances every cycle, valid 10 edges after start
    pat1 = 9'h1C3;
    if1.start = 1;
    tick();
    if1.start = 0;
    n = 1;
    err = 0;
    while (!if1.res_valid && n < 100) begin
      if (if1.sel_o !== 4'(n - 1)) err = 1;
      tick();
      n++;
    end
    check("s0_seq",  32'(err), 0);
    check("s0_lat",  32'(n), 10);
    check("s0_data", 32'(if1.res_data), 32'h1C3);
    if1.res_ready = 1;
    tick();
    if1.res_ready = 0;
    check("s0_acc", 32'(if1.res_valid), 0);

    // N=1, SETTLE=1: valid 3 edges after start
    if2.start = 1;
    tick();
    if2.start = 0;
    n = 1;
    while (!if2.res_valid && n < 100) begin
      tick();
      n++;
    end
    check("n1_lat",  32'(n), 3);
    check("n1_data", 32'(if2.res_data), 1);
    check("n1_sel",  32'(if2.sel_o), 0);
    if2.res_ready = 1;
    tick();
    if2.res_ready = 0;
    check("n1_acc", 32'(if2.res_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
